// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit engine and the future receive engine.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;
    localparam int   UART_STOP_BITS   = 1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and pulses o_bit_done on the last count.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last     = (r_cnt == LAST);
    // Suppress the pulse while held in clear so a clear always restarts a full period.
    assign o_bit_done = w_last & ~i_clr;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit serialiser: start bit, DATA_BITS data bits LSB-first, stop bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 busy
);

    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("uart_tx_engine: CLKS_PER_BIT must be in 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_tx_engine: DATA_BITS must be in 5..8");
    end
    if (UART_STOP_BITS != 1) begin : g_bad_stop_bits
        $error("uart_tx_engine: only one stop bit is supported");
    end

    tx_state_e            r_state;
    logic                 r_txd;
    logic                 r_busy;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shift;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif
    logic                 w_bit_done;
    logic                 w_idle;

    assign w_idle   = (r_state == IDLE);
    assign tx_ready = w_idle;
    assign txd      = r_txd;
    assign busy     = r_busy;

    // Held in clear while idle so the start bit always gets a full period.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_idle),
        .o_bit_done(w_bit_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_txd    <= UART_IDLE_LEVEL;
            r_busy   <= 1'b0;
            r_idx    <= '0;
            r_shift  <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (tx_valid) begin
                        r_state  <= START;
                        r_txd    <= UART_START_LEVEL;
                        r_busy   <= 1'b1;
                        r_shift  <= tx_data;
                        r_idx    <= '0;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^tx_data;
`endif
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_state <= DATA;
                        r_txd   <= r_shift[0];
                        r_idx   <= '0;
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        r_shift <= r_shift >> 1;
                        if (r_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_txd   <= r_parity;
`else
                            r_state <= STOP;
                            r_txd   <= UART_IDLE_LEVEL;
`endif
                        end else begin
                            r_idx <= r_idx + 1'b1;
                            // Next bit is shift[1] because the shift lands on this same edge.
                            r_txd <= r_shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_done) begin
                        r_state <= STOP;
                        r_txd   <= UART_IDLE_LEVEL;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_txd   <= UART_IDLE_LEVEL;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Serialising transmit stage downstream of the UART MMIO register block.
- The register block pushes one byte per write to its TX-data register through a valid/ready handshake.
- This block converts each accepted byte into an asynchronous serial frame on txd: 1 start bit, DATA_BITS data bits LSB-first, 1 stop bit.
- Bit timing comes from a clock-cycle divider.

Parameters:
- CLKS_PER_BIT, default 16: clk cycles per serial bit. Legal range 2..65535; elaboration-time assertion otherwise.
- DATA_BITS, default 8: data bits per frame. Legal range 5..8.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- tx_data  input  DATA_BITS  byte to transmit; sampled only on handshake
- tx_valid  input  1  upstream has a byte
- tx_ready  output  1  engine can accept a byte (high only in IDLE)
- txd  output  1  serial line, idle-high, registered
- busy  output  1  frame in progress (state != IDLE), registered

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, txd=1, busy=0, bit counter=0, baud counter=0, shift register=0.
  - tx_ready is combinational, equal to (state==IDLE), so it reads 1 out of reset.
  - Reset mid-frame aborts immediately: txd returns to 1 on the next edge and the partial frame is discarded.
- Handshake:
  - A byte is accepted on a cycle where tx_valid & tx_ready.
  - tx_data is latched into the shift register.
  - tx_valid while not ready is ignored; there is no internal buffering.
  - tx_data may change freely after acceptance.
- FSM, with baud counter counting 0..CLKS_PER_BIT-1 and bit_done = (baud counter == CLKS_PER_BIT-1):
  - IDLE: txd=1. On accept, go to START; the baud counter clears.
  - START: txd=0 for CLKS_PER_BIT cycles. On bit_done, go to DATA with bit index 0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles. On bit_done, shift right and increment the index. After index DATA_BITS-1, go to STOP (or PARITY, see Optional Feature).
  - STOP: txd=1 for CLKS_PER_BIT cycles. On bit_done, go to IDLE.
- Timing:
  - The txd falling edge appears on the first clk edge after the accept cycle.
  - Frame length is exactly (DATA_BITS+2)*CLKS_PER_BIT cycles.
  - busy rises together with the txd falling edge and falls on the edge that enters IDLE.
- Back-to-back:
  - tx_ready reasserts in the IDLE cycle after STOP completes.
  - A held tx_valid is accepted in that cycle, giving exactly 1 extra idle-high cycle between frames.
- Counters:
  - Baud counter width is $clog2(CLKS_PER_BIT). It wraps to 0 on bit_done and never exceeds CLKS_PER_BIT-1.
  - Bit index width is $clog2(DATA_BITS+1).
- Boundaries:
  - With DATA_BITS<8, the upper tx_data bits beyond DATA_BITS do not exist at the port.
  - With CLKS_PER_BIT=2, every state still holds exactly 2 cycles.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - txd = even parity (XOR of all data bits) for CLKS_PER_BIT cycles.
  - The parity is computed at acceptance and latched.
  - Frame length becomes (DATA_BITS+3)*CLKS_PER_BIT.
- When undefined: no PARITY state, no parity register, and frame timing as above.

Decomposition:
- Shared package uart_pkg holds:
  - the state typedef tx_state_e {IDLE, START, DATA, PARITY, STOP};
  - constants UART_IDLE_LEVEL=1'b1, UART_START_LEVEL=1'b0, UART_STOP_BITS=1.
  - The package is reused by the future receive engine.
- One natural sub-module, uart_baud_tick:
  - free counter with a synchronous clear input and a one-cycle bit_done pulse output;
  - parameterised by CLKS_PER_BIT;
  - shared with the receiver later.

Test Plan:
- Reset: rst held 3 cycles mid-frame -> txd=1, busy=0, tx_ready=1 on the first edge after release; no residual bits.
- Single frame: CLKS_PER_BIT=4, send 0xA5.
  - Expected txd, each level held 4 cycles: 0 | 1,0,1,0,0,1,0,1 | 1.
  - Total frame 40 cycles; busy high for exactly 40 cycles.
- Back-to-back: tx_valid held high with 0x00 then 0xFF -> second start bit begins exactly 41 cycles after the first; one idle-high cycle between frames.
- Ignored stimulus: toggle tx_valid with 0x3C during a frame -> tx_ready=0 throughout, frame content unchanged, 0x3C not transmitted.
- Boundary: CLKS_PER_BIT=2, DATA_BITS=5, send 5'b10011 -> txd 0,1,1,0,0,1,1, each level held 2 cycles; frame 14 cycles.
- Parity (UART_TX_PARITY_EN): CLKS_PER_BIT=4.
  - Send 0xA5 -> parity bit 0, frame 44 cycles.
  - Send 0x07 -> parity bit 1.
